// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and register layout for the UART transmit arbiter.
`timescale 1ns/1ps
package uart_tx_arbiter_pkg;

    localparam int unsigned UART_ARB_MAX_REQ = 8;
    localparam int unsigned GRANT_W          = 3;
    localparam int unsigned IDLE_CNT_W       = 8;
    localparam int unsigned BYTE_W           = 8;

    // FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Arbiter register set
    typedef struct packed {
        logic [0:0]            state;
        logic [GRANT_W-1:0]    grant;
        logic [GRANT_W-1:0]    last_grant;
        logic [IDLE_CNT_W-1:0] idle_cnt;
        logic                  timeout_evt;
    } arb_regs_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set request bit starting after last_grant.
`timescale 1ns/1ps
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] pick,
    output logic               any
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    int unsigned          start;
    int unsigned          offset;

    // Rotate requests so the search start sits at bit 0, then take the lowest set bit
    always_comb begin
        start   = (32'(last_grant) + 32'd1) % NUM_REQ;
        req_dbl = {req, req};
        req_rot = NUM_REQ'(req_dbl >> start);
        offset  = 32'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset = 32'(j);
            end
        end
        any  = |req;
        pick = GRANT_W'((start + offset) % NUM_REQ);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding bytes to a UART transmitter.
`timescale 1ns/1ps
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 255
)(
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 arb_en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_ready,
    output logic                 tx_data_reg_wr,
    output logic [7:0]           tx_data,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_evt
);

    arb_regs_t             r;
    arb_regs_t             r_nxt;
    logic [GRANT_W-1:0]    pick;
    logic                  any_req;
    logic [NUM_REQ-1:0]    grant_oh;
    logic                  g_valid;
    logic                  g_last;
    logic [BYTE_W-1:0]     g_data;
    logic                  xfer;
    logic [IDLE_CNT_W-1:0] cnt_inc;

    rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (r.last_grant),
        .pick       (pick),
        .any        (any_req)
    );

    // State and arbitration registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r.state       <= ST_IDLE;
            r.grant       <= '0;
            r.last_grant  <= GRANT_W'(NUM_REQ - 1);
            r.idle_cnt    <= '0;
            r.timeout_evt <= 1'b0;
        end else begin
            r <= r_nxt;
        end
    end

    // Next-state and per-cycle transfer path of the granted requester
    always_comb begin
        r_nxt             = r;
        r_nxt.timeout_evt = 1'b0;
        grant_oh          = NUM_REQ'(1) << r.grant;
        g_valid           = |(req_valid & grant_oh);
        g_last            = |(req_last & grant_oh);
        g_data            = BYTE_W'(req_data >> (32'(r.grant) * 32'd8));
        cnt_inc           = (r.idle_cnt == '1) ? r.idle_cnt : r.idle_cnt + 8'd1;
        xfer              = 1'b0;
        req_ready         = '0;
        tx_data_reg_wr    = 1'b0;
        tx_data           = '0;
        busy              = 1'b0;
        grant_id          = r.last_grant;

        case (r.state)
            ST_IDLE: begin
                if (arb_en && any_req) begin
                    r_nxt.state    = ST_LOCK;
                    r_nxt.grant    = pick;
                    r_nxt.idle_cnt = '0;
                end
            end
            ST_LOCK: begin
                busy           = 1'b1;
                grant_id       = r.grant;
                tx_data        = g_data;
                req_ready      = tx_ready ? grant_oh : '0;
                xfer           = g_valid && tx_ready;
                tx_data_reg_wr = xfer;
                if (xfer) begin
                    // A transfer always beats a coincident timeout
                    r_nxt.idle_cnt = '0;
                    if (g_last) begin
                        r_nxt.state      = ST_IDLE;
                        r_nxt.last_grant = r.grant;
                    end
                end else begin
                    r_nxt.idle_cnt = cnt_inc;
                    if (cnt_inc >= IDLE_CNT_W'(LOCK_TIMEOUT)) begin
                        r_nxt.state       = ST_IDLE;
                        r_nxt.last_grant  = r.grant;
                        r_nxt.timeout_evt = 1'b1;
                    end
                end
            end
            default: begin
                r_nxt.state = ST_IDLE;
            end
        endcase

        // last_grant resets to NUM_REQ-1, but the owner index must read 0 while held in reset
        if (ARESET) begin
            grant_id = '0;
        end
    end

    assign timeout_evt = r.timeout_evt;

endmodule
